// File: rtl/hilo_op_sequencer_if.sv
// Request, read-hazard and HI/LO write bus of the HI/LO operation sequencer.
// master = decode stage / HI/LO block side, slave = the sequencer itself.
interface hilo_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_sin;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rd_req;
  logic        stall;
  logic        dm_write_en;
  logic [1:0]  dm_op;
  logic        dm_sin;
  logic [31:0] dm_in_1;
  logic [31:0] dm_in_2;
  logic        done;
  logic        div0;

  modport master (
    output req_valid, req_op, req_sin, req_a, req_b, rd_req,
    input  req_ready, stall, dm_write_en, dm_op, dm_sin, dm_in_1, dm_in_2, done, div0
  );

  modport slave (
    input  req_valid, req_op, req_sin, req_a, req_b, rd_req,
    output req_ready, stall, dm_write_en, dm_op, dm_sin, dm_in_1, dm_in_2, done, div0
  );
endinterface

// File: rtl/hilo_op_sequencer.sv
// Multi-cycle sequencer holding MTHI/MTLO/MULT/DIV for a fixed latency before one HI/LO write.
// Optional feature macro HILO_DIV0_TRAP_EN: DIV by zero traps for one cycle instead of writing.
module hilo_op_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  hilo_op_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  // RUN is entered with L-2 so that reaching zero still costs one RUN cycle.
  localparam bit          MUL_MULTI = (MUL_CYCLES > 1);
  localparam bit          DIV_MULTI = (DIV_CYCLES > 1);
  localparam logic [CW-1:0] MUL_LOAD = MUL_MULTI ? CW'(MUL_CYCLES - 2) : '0;
  localparam logic [CW-1:0] DIV_LOAD = DIV_MULTI ? CW'(DIV_CYCLES - 2) : '0;

`ifdef HILO_DIV0_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, COMMIT, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dm_write_en_q, dm_write_en_d;
  logic          done_q, done_d;
  logic [1:0]    dm_op_q, dm_op_d;
  logic          dm_sin_q, dm_sin_d;
  logic [31:0]   dm_in_1_q, dm_in_1_d;
  logic [31:0]   dm_in_2_q, dm_in_2_d;
  logic          accept;
`ifdef HILO_DIV0_TRAP_EN
  logic          div0_q, div0_d;
`endif

  always_comb begin
    accept    = bus.req_valid && (state_q == IDLE);
    state_d   = state_q;
    cnt_d     = cnt_q;
    dm_op_d   = dm_op_q;
    dm_sin_d  = dm_sin_q;
    dm_in_1_d = dm_in_1_q;
    dm_in_2_d = dm_in_2_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dm_op_d   = bus.req_op;
          dm_sin_d  = bus.req_sin;
          dm_in_1_d = bus.req_a;
          dm_in_2_d = bus.req_b;
          state_d   = COMMIT;
          if (bus.req_op == OP_MULT) begin
            if (MUL_MULTI) begin
              state_d = RUN;
              cnt_d   = MUL_LOAD;
            end
          end else if (bus.req_op == OP_DIV) begin
`ifdef HILO_DIV0_TRAP_EN
            if (bus.req_b == 32'd0) begin
              state_d = TRAP;
            end else
`endif
            if (DIV_MULTI) begin
              state_d = RUN;
              cnt_d   = DIV_LOAD;
            end
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      COMMIT:  state_d = IDLE;
`ifdef HILO_DIV0_TRAP_EN
      TRAP:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // Strobes are registered copies of the state being entered.
    dm_write_en_d = (state_d == COMMIT);
`ifdef HILO_DIV0_TRAP_EN
    done_d        = (state_d == COMMIT) || (state_d == TRAP);
    div0_d        = (state_d == TRAP);
`else
    done_d        = (state_d == COMMIT);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dm_write_en_q <= 1'b0;
      done_q        <= 1'b0;
      dm_op_q       <= 2'b00;
      dm_sin_q      <= 1'b0;
      dm_in_1_q     <= 32'd0;
      dm_in_2_q     <= 32'd0;
`ifdef HILO_DIV0_TRAP_EN
      div0_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dm_write_en_q <= dm_write_en_d;
      done_q        <= done_d;
      dm_op_q       <= dm_op_d;
      dm_sin_q      <= dm_sin_d;
      dm_in_1_q     <= dm_in_1_d;
      dm_in_2_q     <= dm_in_2_d;
`ifdef HILO_DIV0_TRAP_EN
      div0_q        <= div0_d;
`endif
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.stall       = bus.rd_req && (state_q != IDLE);
  assign bus.dm_write_en = dm_write_en_q;
  assign bus.done        = done_q;
  assign bus.dm_op       = dm_op_q;
  assign bus.dm_sin      = dm_sin_q;
  assign bus.dm_in_1     = dm_in_1_q;
  assign bus.dm_in_2     = dm_in_2_q;
`ifdef HILO_DIV0_TRAP_EN
  assign bus.div0        = div0_q;
`else
  assign bus.div0        = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_op_sequencer.sv
// Directed testbench for hilo_op_sequencer with a behavioural HI/LO block on the write bus.
// Honours HILO_DIV0_TRAP_EN for the divide-by-zero scenario.
module tb_hilo_op_sequencer;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int          tests_run = 0;
  int          fails = 0;
  int          write_count = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  hilo_op_sequencer_if bus ();

  hilo_op_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(input logic sin, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sin) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; a zero divisor yields an arbitrary but defined pattern.
  function automatic logic [63:0] div64(input logic sin, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sin) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // HI/LO block: updates at the closing edge of the write-strobe cycle.
  always @(posedge clk) begin
    if (bus.dm_write_en) begin
      write_count <= write_count + 1;
      case (bus.dm_op)
        2'b00:   hi_m <= bus.dm_in_1;
        2'b01:   lo_m <= bus.dm_in_1;
        2'b10:   {hi_m, lo_m} <= mul64(bus.dm_sin, bus.dm_in_1, bus.dm_in_2);
        default: {hi_m, lo_m} <= div64(bus.dm_sin, bus.dm_in_1, bus.dm_in_2);
      endcase
    end
  end

  // Presents one request for a single edge; returns at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [1:0] op, input logic sin,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_sin   = sin;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b11;
    bus.req_sin   = 1'b1;
    bus.req_a     = 32'hA5A5_A5A5;
    bus.req_b     = 32'h5A5A_5A5A;
    bus.rd_req    = 1'b1;
    reset         = 1'b0;
    #12;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready); end
    tests_run++;
    if (bus.stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
    tests_run++;
    if ({bus.dm_write_en, bus.done, bus.div0, bus.dm_sin} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {bus.dm_write_en, bus.done, bus.div0, bus.dm_sin});
    end
    tests_run++;
    if ({bus.dm_op, bus.dm_in_1, bus.dm_in_2} !== 66'd0) begin
      fails++; $display("[TB] FAIL reset_operands: got %h expected 0", {bus.dm_op, bus.dm_in_1, bus.dm_in_2});
    end
    @(negedge clk);
    reset      = 1'b1;
    bus.rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    applyStimulus(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd2);
    for (int k = 1; k <= 5; k++) begin
      tests_run++;
      if (bus.dm_write_en !== (k == 4)) begin fails++; $display("[TB] FAIL mult_write c%0d: got %b expected %b", k, bus.dm_write_en, (k == 4)); end
      tests_run++;
      if (bus.req_ready !== (k == 5)) begin fails++; $display("[TB] FAIL mult_ready c%0d: got %b expected %b", k, bus.req_ready, (k == 5)); end
      if (k == 4) begin
        tests_run++;
        if (bus.dm_op !== 2'b10) begin fails++; $display("[TB] FAIL mult_op: got %b expected 10", bus.dm_op); end
        tests_run++;
        if (bus.done !== 1'b1) begin fails++; $display("[TB] FAIL mult_done: got %b expected 1", bus.done); end
      end
      @(negedge clk);
    end
    tests_run++;
    if (hi_m !== 32'h0000_0001) begin fails++; $display("[TB] FAIL mult_hi: got %h expected 00000001", hi_m); end
    tests_run++;
    if (lo_m !== 32'hFFFF_FFFE) begin fails++; $display("[TB] FAIL mult_lo: got %h expected fffffffe", lo_m); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_sin   = 1'b1;
    bus.req_a     = 32'hFFFF_FFFD;
    bus.req_b     = 32'd5;
    bus.rd_req    = 1'b1;
    #1;
    tests_run++;
    if (bus.stall !== 1'b0) begin fails++; $display("[TB] FAIL hazard_accept_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tests_run++;
      if (bus.stall !== (k <= 4)) begin fails++; $display("[TB] FAIL hazard_stall c%0d: got %b expected %b", k, bus.stall, (k <= 4)); end
      @(negedge clk);
    end
    bus.rd_req = 1'b0;
    tests_run++;
    if ({hi_m, lo_m} !== 64'hFFFF_FFFF_FFFF_FFF1) begin fails++; $display("[TB] FAIL hazard_smult: got %h expected fffffffffffffff1", {hi_m, lo_m}); end
  endtask

  task automatic test_div();
    applyStimulus(2'b11, 1'b1, 32'd100, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      tests_run++;
      if (bus.done !== (k == 32)) begin fails++; $display("[TB] FAIL div_done c%0d: got %b expected %b", k, bus.done, (k == 32)); end
      tests_run++;
      if (bus.req_ready !== (k == 33)) begin fails++; $display("[TB] FAIL div_ready c%0d: got %b expected %b", k, bus.req_ready, (k == 33)); end
      if (k == 32) begin
        tests_run++;
        if ({bus.dm_sin, bus.dm_op, bus.dm_write_en} !== 4'b1111) begin
          fails++; $display("[TB] FAIL div_commit: got %b expected 1111", {bus.dm_sin, bus.dm_op, bus.dm_write_en});
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (hi_m !== 32'd2) begin fails++; $display("[TB] FAIL div_hi: got %h expected 00000002", hi_m); end
    tests_run++;
    if (lo_m !== 32'd14) begin fails++; $display("[TB] FAIL div_lo: got %h expected 0000000e", lo_m); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi_before;
    hi_before = hi_m;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_sin   = 1'b0;
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'd0;
    @(negedge clk);
    tests_run++;
    if ({bus.dm_write_en, bus.dm_op, bus.req_ready} !== 4'b1010) begin
      fails++; $display("[TB] FAIL mtlo_commit: got %b expected 1010", {bus.dm_write_en, bus.dm_op, bus.req_ready});
    end
    bus.req_op = 2'b00;
    bus.req_a  = 32'h1234_5678;
    @(negedge clk);
    tests_run++;
    if ({bus.req_ready, bus.dm_write_en} !== 2'b10) begin fails++; $display("[TB] FAIL b2b_idle: got %b expected 10", {bus.req_ready, bus.dm_write_en}); end
    tests_run++;
    if (bus.dm_in_1 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL b2b_hold_in1: got %h expected deadbeef", bus.dm_in_1); end
    tests_run++;
    if (lo_m !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL mtlo_lo: got %h expected deadbeef", lo_m); end
    tests_run++;
    if (hi_m !== hi_before) begin fails++; $display("[TB] FAIL mtlo_hi: got %h expected %h", hi_m, hi_before); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests_run++;
    if ({bus.dm_write_en, bus.dm_op} !== 3'b100) begin fails++; $display("[TB] FAIL mthi_commit: got %b expected 100", {bus.dm_write_en, bus.dm_op}); end
    tests_run++;
    if (bus.dm_in_1 !== 32'h1234_5678) begin fails++; $display("[TB] FAIL mthi_in1: got %h expected 12345678", bus.dm_in_1); end
    @(negedge clk);
    tests_run++;
    if ({hi_m, lo_m} !== 64'h1234_5678_DEAD_BEEF) begin fails++; $display("[TB] FAIL mthi_hilo: got %h expected 12345678deadbeef", {hi_m, lo_m}); end
  endtask

  task automatic test_div0();
    logic [63:0] hilo_before;
    int          wc_before;
    hilo_before = {hi_m, lo_m};
    wc_before   = write_count;
    applyStimulus(2'b11, 1'b0, 32'd5, 32'd0);
`ifdef HILO_DIV0_TRAP_EN
    for (int k = 1; k <= 34; k++) begin
      tests_run++;
      if ({bus.div0, bus.done} !== {(k == 1), (k == 1)}) begin
        fails++; $display("[TB] FAIL div0_trap c%0d: got %b expected %b", k, {bus.div0, bus.done}, {(k == 1), (k == 1)});
      end
      tests_run++;
      if (bus.dm_write_en !== 1'b0) begin fails++; $display("[TB] FAIL div0_nowrite c%0d: got %b expected 0", k, bus.dm_write_en); end
      @(negedge clk);
    end
    tests_run++;
    if ({hi_m, lo_m} !== hilo_before) begin fails++; $display("[TB] FAIL div0_hilo: got %h expected %h", {hi_m, lo_m}, hilo_before); end
    tests_run++;
    if (write_count !== wc_before) begin fails++; $display("[TB] FAIL div0_writes: got %0d expected %0d", write_count, wc_before); end
`else
    for (int k = 1; k <= 33; k++) begin
      tests_run++;
      if (bus.div0 !== 1'b0) begin fails++; $display("[TB] FAIL div0_flag c%0d: got %b expected 0", k, bus.div0); end
      tests_run++;
      if (bus.dm_write_en !== (k == 32)) begin fails++; $display("[TB] FAIL div0_write c%0d: got %b expected %b", k, bus.dm_write_en, (k == 32)); end
      @(negedge clk);
    end
    tests_run++;
    if (write_count !== wc_before + 1) begin fails++; $display("[TB] FAIL div0_writes: got %0d expected %0d", write_count, wc_before + 1); end
`endif
  endtask

  task automatic test_reset_mid();
    int wc_before;
    wc_before = write_count;
    applyStimulus(2'b11, 1'b1, 32'd9, 32'd3);
    for (int k = 1; k < 10; k++) @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b0) begin fails++; $display("[TB] FAIL rmid_busy: got %b expected 0", bus.req_ready); end
    bus.rd_req = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.req_ready, bus.stall, bus.dm_write_en, bus.done, bus.div0} !== 5'b10000) begin
      fails++; $display("[TB] FAIL rmid_ctrl: got %b expected 10000", {bus.req_ready, bus.stall, bus.dm_write_en, bus.done, bus.div0});
    end
    tests_run++;
    if ({bus.dm_op, bus.dm_sin, bus.dm_in_1, bus.dm_in_2} !== 67'd0) begin
      fails++; $display("[TB] FAIL rmid_operands: got %h expected 0", {bus.dm_op, bus.dm_sin, bus.dm_in_1, bus.dm_in_2});
    end
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b1;
    bus.rd_req = 1'b0;
    for (int k = 0; k < 30; k++) @(negedge clk);
    tests_run++;
    if (write_count !== wc_before) begin fails++; $display("[TB] FAIL rmid_nowrite: got %0d expected %0d", write_count, wc_before); end
    tests_run++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("[TB] FAIL rmid_ready: got %b expected 1", bus.req_ready); end
    applyStimulus(2'b10, 1'b0, 32'd3, 32'd4);
    for (int k = 1; k <= 5; k++) begin
      tests_run++;
      if (bus.dm_write_en !== (k == 4)) begin fails++; $display("[TB] FAIL rmid_mult_write c%0d: got %b expected %b", k, bus.dm_write_en, (k == 4)); end
      @(negedge clk);
    end
    tests_run++;
    if ({hi_m, lo_m} !== 64'd12) begin fails++; $display("[TB] FAIL rmid_mult_hilo: got %h expected 000000000000000c", {hi_m, lo_m}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_hazard();
    test_div();
    test_back_to_back();
    test_div0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/hilo_op_sequencer.md
# hilo_op_sequencer

Multi-cycle sequencer in front of the HI/LO multiply/divide register block. It accepts MTHI/MTLO/MULT/DIV requests from the decode stage with a valid/ready handshake and holds each operation for a fixed per-class latency, modelling iterative multiply/divide timing. It then issues a single write strobe with stable operands to the HI/LO block. While an operation is in flight it stalls MFHI/MFLO reads.

## Interface
Parameters:
- MUL_CYCLES, 4, MULT latency in cycles (≥1)
- DIV_CYCLES, 32, DIV latency in cycles (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  decode presents an operation
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_op  in  2  00 MTHI, 01 MTLO, 10 MULT, 11 DIV
- req_sin  in  1  signed operation (MULT/DIV)
- req_a  in  32  rs operand / MTHI/MTLO source
- req_b  in  32  rt operand
- rd_req  in  1  MFHI/MFLO present in decode
- stall  out  1  hold the pipeline (read hazard)
- dm_write_en  out  1  write strobe to HI/LO block
- dm_op  out  2  op to HI/LO block (same encoding as req_op)
- dm_sin  out  1  signedness to HI/LO block
- dm_in_1  out  32  latched req_a
- dm_in_2  out  32  latched req_b
- done  out  1  one-cycle completion pulse
- div0  out  1  one-cycle divide-by-zero flag (see Configuration)

## Operation
- States: IDLE, RUN, COMMIT (plus TRAP when HILO_DIV0_TRAP_EN is defined).
- Accept: req_valid && req_ready at a rising edge. This latches req_op, req_sin, req_a and req_b into the dm_* registers and loads the down-counter.
- Latency L: 1 for MTHI/MTLO, MUL_CYCLES for MULT, DIV_CYCLES for DIV.
- Transitions:
  - IDLE → COMMIT when L = 1.
  - IDLE → RUN when L > 1, with counter = L−2.
  - RUN decrements the counter and goes to COMMIT when it reaches 0.
  - COMMIT → IDLE unconditionally.
- COMMIT: dm_write_en = 1 and done = 1 for exactly one cycle. HI/LO update at the closing edge of the COMMIT cycle.
- dm_op, dm_sin, dm_in_1 and dm_in_2 stay constant from the accept edge until the next accept. They are never updated outside IDLE.
- req_ready = (state == IDLE). Requests are not accepted in COMMIT, so back-to-back throughput is L+1 cycles per operation.
- stall = rd_req && (state != IDLE). An MFHI/MFLO in the cycle after COMMIT reads the new value.
- Counter width: clog2(max(MUL_CYCLES, DIV_CYCLES)+1).
- MTHI/MTLO pass req_a unchanged. The sequencer never computes any arithmetic result itself.

## Timing
- Reset values (asynchronous assert, synchronous deassert by the surrounding reset tree): state IDLE, counter 0, dm_write_en 0, dm_op 00, dm_sin 0, dm_in_1 0, dm_in_2 0, done 0, div0 0. req_ready reads 1 and stall reads 0 throughout reset.
- Accept at edge E0 → dm_write_en and done are high in the L-th cycle after E0 → req_ready is high in cycle L+1.
- Reset during RUN or COMMIT abandons the operation: no write is issued, and the cycle holding reset low shows dm_write_en = 0.
- rd_req coinciding with an accept in IDLE: stall = 0, and the read completes before the write. The decode stage guarantees in-order issue.
- req_valid deasserted while in RUN: no effect.

## Configuration
- HILO_DIV0_TRAP_EN defined: a DIV accepted with req_b == 0 goes IDLE → TRAP → IDLE.
  - TRAP lasts one cycle with done = 1, div0 = 1 and dm_write_en = 0, so HI/LO are unchanged.
  - Latency is 1 regardless of DIV_CYCLES.
- Not defined: div0 is tied to 0 and the TRAP state does not exist. A DIV by zero runs the full DIV_CYCLES and writes whatever the HI/LO block produces.

## Test plan
- MULT unsigned: a = 0xFFFFFFFF, b = 2, MUL_CYCLES = 4, accept at E0.
  - dm_write_en is high only in cycle 4 with dm_op = 10.
  - The attached HI/LO block then holds HI = 0x00000001, LO = 0xFFFFFFFE.
  - req_ready rises in cycle 5.
- DIV signed: a = 100, b = 7, DIV_CYCLES = 32.
  - done is high only in cycle 32 with dm_sin = 1 and dm_op = 11.
  - HI = 2, LO = 14.
  - req_ready is 0 in cycles 1–32.
- MTLO: a = 0xDEADBEEF.
  - dm_write_en is high in cycle 1 with dm_op = 01.
  - LO = 0xDEADBEEF and HI is unchanged.
  - A second MTHI is accepted at cycle 2.
- Hazard: rd_req held high from cycle 1 after a MULT accept.
  - stall = 1 for cycles 1–4.
  - stall = 0 in cycle 5.
- Divide by zero: DIV with a = 5, b = 0.
  - With HILO_DIV0_TRAP_EN: div0 = done = 1 in cycle 1, dm_write_en never asserts, HI/LO are unchanged.
  - Without it: div0 stays 0 and dm_write_en asserts in cycle 32.
- Reset mid-operation: reset is driven low at cycle 10 of a DIV.
  - All outputs go to their reset values immediately, and dm_write_en never asserts for that DIV.
  - After release, req_ready = 1 and a new MULT completes normally.
